mm_sequencer: RTL and testbench
===============================

Name: mm_sequencer

Overview:
- Parametrised operation sequencer for the DNN training accelerator. Generalises the matrix-multiply controller to NBANK register-file banks and arbitrary non-square M x N x K tiles.
- Accepts one operation at a time over a valid/ready handshake: matmul, serial write, serial read.
- Drives bank page selects, shift enables and switch strobes, and waits a fixed drain latency before signalling done.
- Adds an accumulate mode and rejects illegal operations, which the previous controller did not.

Parameters:
NBANK, 4, number of register-file banks (power of 2, >=2)
BANK_W, 2, log2(NBANK)
PG_W, 2, page-number bits per bank
DIM_W, 6, width of each dimension field (dimensions encoded minus-one)
ARR, 8, systolic array edge (width of the row-valid vectors)
DRAIN, 12, cycles from last shift to completion (multiplier flush latency)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  global enable; when low all state holds
op_valid  in  1  operation offered
op_ready  out  1  sequencer idle and able to accept
op_code  in  4  0 idle, 1 matmul, 2 serial write, 3 serial read
op_x  in  BANK_W+PG_W  X source {bank,page}; also the page for opcodes 2/3
op_w  in  BANK_W+PG_W  W source
op_y  in  BANK_W+PG_W  Y destination
op_cfg  in  4  {accumulate, store_b, relu, transpose}
dim_m, dim_n, dim_k  in  DIM_W each  X lines-1, W lines-1, cells per line-1
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  valid together with done; operation rejected
shift_en  out  1  banks shift data to the array
bank_switch  out  NBANK  per-bank line-switch strobe
bank_rd_page  out  NBANK*PG_W  read page per bank
bank_wr_page  out  NBANK*PG_W  write page per bank
bank_we  out  NBANK*2  per bank: 0 none, 1 serial, 2 bulk, 3 bulk-accumulate
bank_re  out  NBANK  serial read strobe per bank
x_sel, w_sel, y_sel  out  BANK_W each  datapath mux selects (latched)
cfg_q  out  4  latched op_cfg
ser_idx  out  2*DIM_W  serial element index
row_clear  in  ARR  multiplier row-complete flags
y_valid  out  ARR  row_clear delayed one cycle

Behaviour:
- Reset (reset==0 at posedge):
  - FSM to IDLE; all counters 0.
  - busy, done, err, shift_en, bank_switch, bank_we, bank_re, y_valid, cfg_q, sel outputs, ser_idx all 0.
  - Reset mid-operation aborts it silently (no done).
- enable low: no state changes, no done pulse; outputs hold.
- FSM states: IDLE, SHIFT, SERIAL, DRAIN, DONE.
- Operation acceptance:
  - Handshake: op_ready = (state==IDLE) & enable & reset. Accept occurs when op_valid & op_ready. All op fields and dims are latched on that cycle.
  - op_code 0 accepted: no effect, no done.
  - Illegal op (op_code >3, or matmul with y bank equal to x or w bank): next state DONE with err=1; no bank strobes.
- Matmul (SHIFT):
  - Counters wc 0..K, wl 0..N, xl 0..M.
  - w_sw = (wc==K); x_sw = w_sw & (wl==N).
  - wc wraps on w_sw. wl increments on w_sw and wraps at N. xl increments on x_sw.
  - shift_en is high every SHIFT cycle, (K+1)(N+1)(M+1) cycles total, starting the cycle after accept.
  - Switch routing: X bank receives x_sw and W bank receives w_sw; routing is swapped when transpose=1. Other banks get 0.
  - Last shift (x_sw & xl==M) -> DRAIN.
- DRAIN:
  - Counts DRAIN cycles.
  - During SHIFT and DRAIN, y bank bank_we = 2 (3 if accumulate); store_b bank unused here.
  - Then DONE.
- Serial (opcodes 2/3):
  - Length L = (N+1)(K+1); ser_idx runs 0..L-1, one step per enabled cycle.
  - Target bank gets bank_we=1 (op 2) or bank_re=1 (op 3) each cycle; rd/wr page = op_x page.
  - After index L-1 -> DONE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in all states except IDLE.
- y_valid <= row_clear whenever enable is high, in all states.
- Dimensions of 0 are legal (1x1x1 = 1 shift cycle); all-ones dims give 2^(3*DIM_W) cycles with no counter overflow.

Test Plan:
- Reset low during SHIFT at cycle 5 -> next cycle busy=0, op_ready=1, shift_en=0, no done pulse.
- Matmul M=1,N=1,K=3 (encoded 1,1,3), x=bank0, w=bank1, y=bank2 -> shift_en for exactly 16 cycles; bank1 switch strobes on cycles 4,8,12,16; bank0 strobes on 8,16; done exactly 16+DRAIN+1 cycles after accept.
- Same op with transpose=1 -> bank0/bank1 strobe patterns swap; accumulate=1 -> bank2 bank_we=3 throughout SHIFT and DRAIN.
- Serial write page 0x5 (bank1, page1), N=0,K=2 -> bank_we[bank1]=1 for 3 cycles with ser_idx 0,1,2, bank_wr_page=1, then done.
- Matmul with y bank == x bank -> no shift_en, done and err high together one cycle after accept.
- enable low for 4 cycles mid-SHIFT -> counters freeze; total shift_en cycles still 16; done delayed by 4.

Source files
------------

// File: rtl/mm_sequencer_if.sv
// Operation handshake and status channel between an op issuer and mm_sequencer.
interface mm_sequencer_if #(
  parameter int unsigned BANK_W = 2,
  parameter int unsigned PG_W   = 2,
  parameter int unsigned DIM_W  = 6
);
  logic                   op_valid;
  logic                   op_ready;
  logic [3:0]             op_code;
  logic [BANK_W+PG_W-1:0] op_x;
  logic [BANK_W+PG_W-1:0] op_w;
  logic [BANK_W+PG_W-1:0] op_y;
  logic [3:0]             op_cfg;
  logic [DIM_W-1:0]       dim_m;
  logic [DIM_W-1:0]       dim_n;
  logic [DIM_W-1:0]       dim_k;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output op_valid, op_code, op_x, op_w, op_y, op_cfg, dim_m, dim_n, dim_k,
    input  op_ready, busy, done, err
  );

  modport slave (
    input  op_valid, op_code, op_x, op_w, op_y, op_cfg, dim_m, dim_n, dim_k,
    output op_ready, busy, done, err
  );
endinterface

// File: rtl/mm_sequencer.sv
// Operation sequencer: runs M x N x K matmul shifts, serial bank access and the
// multiplier drain, driving bank strobes and page selects.
module mm_sequencer #(
  parameter int unsigned NBANK  = 4,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned PG_W   = 2,
  parameter int unsigned DIM_W  = 6,
  parameter int unsigned ARR    = 8,
  parameter int unsigned DRAIN  = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  mm_sequencer_if.slave         op_if,
  output logic                  shift_en_o,
  output logic [NBANK-1:0]      bank_switch_o,
  output logic [NBANK*PG_W-1:0] bank_rd_page_o,
  output logic [NBANK*PG_W-1:0] bank_wr_page_o,
  output logic [NBANK*2-1:0]    bank_we_o,
  output logic [NBANK-1:0]      bank_re_o,
  output logic [BANK_W-1:0]     x_sel_o,
  output logic [BANK_W-1:0]     w_sel_o,
  output logic [BANK_W-1:0]     y_sel_o,
  output logic [3:0]            cfg_q_o,
  output logic [2*DIM_W-1:0]    ser_idx_o,
  input  logic [ARR-1:0]        row_clear_i,
  output logic [ARR-1:0]        y_valid_o
);

  localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [2:0] {StIdle, StShift, StSerial, StDrain, StDone} state_e;

  state_e              state_q;
  logic                busy_q, done_q, err_q, wr_op_q;
  logic [DIM_W-1:0]    m_q, n_q, k_q, wc_q, wl_q, xl_q;
  logic [DCW-1:0]      dc_q;
  logic [2*DIM_W-1:0]  ser_idx_q;
  logic [BANK_W-1:0]   x_sel_q, w_sel_q, y_sel_q;
  logic [PG_W-1:0]     x_pg_q, w_pg_q, y_pg_q;
  logic [3:0]          cfg_q;
  logic [ARR-1:0]      y_valid_q;

  logic [BANK_W-1:0]   in_xb, in_wb, in_yb;
  logic                illegal, w_sw, x_sw, mm_last;

  assign in_xb   = op_if.op_x[PG_W +: BANK_W];
  assign in_wb   = op_if.op_w[PG_W +: BANK_W];
  assign in_yb   = op_if.op_y[PG_W +: BANK_W];
  assign illegal = (op_if.op_code > 4'd3) ||
                   ((op_if.op_code == 4'd1) && ((in_yb == in_xb) || (in_yb == in_wb)));

  // Serial ops reuse wc/wl as a (N+1) x (K+1) walk; x_sw marks its last element.
  assign w_sw    = (wc_q == k_q);
  assign x_sw    = w_sw && (wl_q == n_q);
  assign mm_last = x_sw && (xl_q == m_q);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_op_q   <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      wc_q      <= '0;
      wl_q      <= '0;
      xl_q      <= '0;
      dc_q      <= '0;
      ser_idx_q <= '0;
      x_sel_q   <= '0;
      w_sel_q   <= '0;
      y_sel_q   <= '0;
      x_pg_q    <= '0;
      w_pg_q    <= '0;
      y_pg_q    <= '0;
      cfg_q     <= '0;
      y_valid_q <= '0;
    end else if (enable_i) begin
      y_valid_q <= row_clear_i;
      unique case (state_q)
        StIdle: begin
          if (op_if.op_valid && (op_if.op_code != 4'd0)) begin
            x_sel_q   <= in_xb;
            w_sel_q   <= in_wb;
            y_sel_q   <= in_yb;
            x_pg_q    <= op_if.op_x[PG_W-1:0];
            w_pg_q    <= op_if.op_w[PG_W-1:0];
            y_pg_q    <= op_if.op_y[PG_W-1:0];
            cfg_q     <= op_if.op_cfg;
            m_q       <= op_if.dim_m;
            n_q       <= op_if.dim_n;
            k_q       <= op_if.dim_k;
            wr_op_q   <= (op_if.op_code == 4'd2);
            wc_q      <= '0;
            wl_q      <= '0;
            xl_q      <= '0;
            dc_q      <= '0;
            ser_idx_q <= '0;
            busy_q    <= 1'b1;
            if (illegal) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (op_if.op_code == 4'd1) begin
              state_q <= StShift;
            end else begin
              state_q <= StSerial;
            end
          end
        end
        StShift: begin
          wc_q <= w_sw ? '0 : wc_q + DIM_W'(1);
          if (w_sw) wl_q <= (wl_q == n_q) ? '0 : wl_q + DIM_W'(1);
          if (x_sw) xl_q <= xl_q + DIM_W'(1);
          if (mm_last) begin
            state_q <= StDrain;
            xl_q    <= '0;
          end
        end
        StSerial: begin
          ser_idx_q <= ser_idx_q + (2*DIM_W)'(1);
          wc_q      <= w_sw ? '0 : wc_q + DIM_W'(1);
          if (w_sw) wl_q <= (wl_q == n_q) ? '0 : wl_q + DIM_W'(1);
          if (x_sw) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDrain: begin
          if (dc_q == DCW'(DRAIN - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            dc_q    <= '0;
          end else begin
            dc_q <= dc_q + DCW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes are qualified by enable so a frozen sequencer never moves bank data.
  always_comb begin
    bank_switch_o  = '0;
    bank_we_o      = '0;
    bank_re_o      = '0;
    bank_rd_page_o = '0;
    bank_wr_page_o = '0;
    if ((state_q == StShift) && enable_i) begin
      bank_switch_o[x_sel_q] = cfg_q[0] ? w_sw : x_sw;
      bank_switch_o[w_sel_q] = bank_switch_o[w_sel_q] | (cfg_q[0] ? x_sw : w_sw);
    end
    if (((state_q == StShift) || (state_q == StDrain)) && enable_i) begin
      bank_we_o[int'(y_sel_q)*2 +: 2] = cfg_q[3] ? 2'd3 : 2'd2;
    end
    if ((state_q == StSerial) && enable_i) begin
      if (wr_op_q) bank_we_o[int'(x_sel_q)*2 +: 2] = 2'd1;
      else         bank_re_o[x_sel_q] = 1'b1;
    end
    if ((state_q == StShift) || (state_q == StDrain)) begin
      bank_rd_page_o[int'(x_sel_q)*PG_W +: PG_W] = x_pg_q;
      bank_rd_page_o[int'(w_sel_q)*PG_W +: PG_W] = w_pg_q;
      bank_wr_page_o[int'(y_sel_q)*PG_W +: PG_W] = y_pg_q;
    end
    if (state_q == StSerial) begin
      bank_rd_page_o[int'(x_sel_q)*PG_W +: PG_W] = x_pg_q;
      bank_wr_page_o[int'(x_sel_q)*PG_W +: PG_W] = x_pg_q;
    end
  end

  assign op_if.op_ready = (state_q == StIdle) && enable_i && reset_ni;
  assign op_if.busy     = busy_q;
  assign op_if.done     = done_q && enable_i;
  assign op_if.err      = err_q && enable_i;
  assign shift_en_o     = (state_q == StShift) && enable_i;
  assign x_sel_o        = x_sel_q;
  assign w_sel_o        = w_sel_q;
  assign y_sel_o        = y_sel_q;
  assign cfg_q_o        = cfg_q;
  assign ser_idx_o      = ser_idx_q;
  assign y_valid_o      = y_valid_q;

endmodule

// File: tb/tb_mm_sequencer.sv
// Randomized bench for mm_sequencer: per-op expected cycle traces, checked every cycle.
module tb_mm_sequencer;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int PW = 2;
  localparam int DW = 6;
  localparam int AR = 8;
  localparam int DR = 12;

  typedef struct {
    bit          shift;
    bit [NB-1:0] sw;
    bit [2*NB-1:0] we;
    bit [NB-1:0] re;
    bit          done;
    bit          err;
    bit          ser;
    bit          rd;
    int          idx;
    int          bank;
    int          pg;
  } rec_t;

  logic            clk = 1'b0;
  logic            reset_n, enable;
  logic [AR-1:0]   row_clear, y_valid;
  logic            shift_en;
  logic [NB-1:0]   bank_switch, bank_re;
  logic [NB*PW-1:0] bank_rd_page, bank_wr_page;
  logic [2*NB-1:0] bank_we;
  logic [BW-1:0]   x_sel, w_sel, y_sel;
  logic [3:0]      cfg_q;
  logic [2*DW-1:0] ser_idx;

  mm_sequencer_if #(.BANK_W(BW), .PG_W(PW), .DIM_W(DW)) op_if ();

  mm_sequencer #(
    .NBANK(NB), .BANK_W(BW), .PG_W(PW), .DIM_W(DW), .ARR(AR), .DRAIN(DR)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .enable_i      (enable),
    .op_if         (op_if),
    .shift_en_o    (shift_en),
    .bank_switch_o (bank_switch),
    .bank_rd_page_o(bank_rd_page),
    .bank_wr_page_o(bank_wr_page),
    .bank_we_o     (bank_we),
    .bank_re_o     (bank_re),
    .x_sel_o       (x_sel),
    .w_sel_o       (w_sel),
    .y_sel_o       (y_sel),
    .cfg_q_o       (cfg_q),
    .ser_idx_o     (ser_idx),
    .row_clear_i   (row_clear),
    .y_valid_o     (y_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state
  rec_t        exp_q[$];
  logic [AR-1:0] y_exp = '0;
  bit          mon_on = 0, rand_en = 0, accepted = 0;
  int          cyc = 0, acc_cyc = 0, shift_cnt = 0, done_rel = -1, done_cnt = 0;
  int          we3_cnt = 0, we1_cnt = 0;
  bit          done_err = 0;
  logic [63:0] m0 = '0, m1 = '0;
  int          ex_xb = 0, ex_wb = 0, ex_yb = 0, ex_cfg = 0;

  function automatic void build(input logic [3:0] code, input logic [3:0] x, input logic [3:0] w,
                                input logic [3:0] y, input logic [3:0] cfg,
                                input int m, input int n, input int k);
    rec_t r;
    int xb = int'(x[3:2]);
    int wb = int'(w[3:2]);
    int yb = int'(y[3:2]);
    bit bad = (code > 3) || ((code == 1) && ((yb == xb) || (yb == wb)));
    if (bad) begin
      r = '{default: 0};
      r.done = 1; r.err = 1;
      exp_q.push_back(r);
      return;
    end
    if (code == 1) begin
      for (int i = 0; i < (m + 1) * (n + 1) * (k + 1); i++) begin
        int wc = i % (k + 1);
        int wl = (i / (k + 1)) % (n + 1);
        bit wsw = (wc == k);
        bit xsw = wsw && (wl == n);
        r = '{default: 0};
        r.shift = 1;
        r.sw[xb] = cfg[0] ? wsw : xsw;
        r.sw[wb] = r.sw[wb] | (cfg[0] ? xsw : wsw);
        r.we[yb*2 +: 2] = cfg[3] ? 2'd3 : 2'd2;
        exp_q.push_back(r);
      end
      for (int i = 0; i < DR; i++) begin
        r = '{default: 0};
        r.we[yb*2 +: 2] = cfg[3] ? 2'd3 : 2'd2;
        exp_q.push_back(r);
      end
    end else begin
      for (int i = 0; i < (n + 1) * (k + 1); i++) begin
        r = '{default: 0};
        r.ser = 1; r.idx = i; r.bank = xb; r.pg = int'(x[1:0]); r.rd = (code == 3);
        if (code == 2) r.we[xb*2 +: 2] = 2'd1;
        else           r.re[xb] = 1'b1;
        exp_q.push_back(r);
      end
    end
    r = '{default: 0};
    r.done = 1;
    exp_q.push_back(r);
  endfunction

  // Compare process: outputs are stable mid-cycle, inputs were driven just after posedge.
  always @(negedge clk) begin
    rec_t r;
    bit busy_e, ready_e;
    int rel;
    if (mon_on) begin
      cyc++;
      busy_e  = (exp_q.size() != 0);
      ready_e = !busy_e && enable && reset_n;
      r = '{default: 0};
      if (busy_e && enable) r = exp_q[0];
      chk("op_ready", op_if.op_ready, ready_e);
      chk("busy", op_if.busy, busy_e);
      chk("y_valid", y_valid, y_exp);
      chk("shift_en", shift_en, r.shift);
      chk("bank_switch", bank_switch, r.sw);
      chk("bank_we", bank_we, r.we);
      chk("bank_re", bank_re, r.re);
      chk("done", op_if.done, r.done);
      chk("err", op_if.err, r.err);
      if (r.ser) begin
        chk("ser_idx", ser_idx, r.idx);
        if (r.rd) chk("rd_page", bank_rd_page[r.bank*PW +: PW], r.pg);
        else      chk("wr_page", bank_wr_page[r.bank*PW +: PW], r.pg);
      end
      if (busy_e) begin
        chk("x_sel", x_sel, ex_xb);
        chk("w_sel", w_sel, ex_wb);
        chk("y_sel", y_sel, ex_yb);
        chk("cfg_q", cfg_q, ex_cfg);
      end
      rel = cyc - acc_cyc;
      if (shift_en === 1'b1) shift_cnt++;
      if (bank_we[5:4] == 2'd3) we3_cnt++;
      if (bank_we[3:2] == 2'd1) we1_cnt++;
      if (rel < 64 && bank_switch[0] === 1'b1) m0[rel] = 1'b1;
      if (rel < 64 && bank_switch[1] === 1'b1) m1[rel] = 1'b1;
      if (op_if.done === 1'b1) begin
        done_rel = rel; done_err = op_if.err; done_cnt++;
      end
      if (!reset_n) begin
        exp_q.delete();
        y_exp = '0;
        ex_xb = 0; ex_wb = 0; ex_yb = 0; ex_cfg = 0;
      end else if (enable) begin
        y_exp = row_clear;
        if (busy_e) begin
          void'(exp_q.pop_front());
        end else if (op_if.op_valid) begin
          accepted = 1; acc_cyc = cyc; shift_cnt = 0; done_rel = -1;
          we3_cnt = 0; we1_cnt = 0; m0 = '0; m1 = '0;
          if (op_if.op_code != 0) begin
            ex_xb = int'(op_if.op_x[3:2]); ex_wb = int'(op_if.op_w[3:2]);
            ex_yb = int'(op_if.op_y[3:2]); ex_cfg = int'(op_if.op_cfg);
            build(op_if.op_code, op_if.op_x, op_if.op_w, op_if.op_y, op_if.op_cfg,
                  int'(op_if.dim_m), int'(op_if.dim_n), int'(op_if.dim_k));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      row_clear = AR'($urandom);
      if (rand_en) enable = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 20000) begin tick(); g++; end
    chk("idle_timeout", (g < 20000), 1);
  endtask

  task automatic send(input logic [3:0] code, input logic [3:0] x, input logic [3:0] w,
                      input logic [3:0] y, input logic [3:0] cfg,
                      input int m, input int n, input int k);
    int g = 0;
    wait_idle();
    op_if.op_code = code; op_if.op_x = x; op_if.op_w = w; op_if.op_y = y;
    op_if.op_cfg = cfg; op_if.dim_m = DW'(m); op_if.dim_n = DW'(n); op_if.dim_k = DW'(k);
    accepted = 0;
    op_if.op_valid = 1'b1;
    do begin tick(); g++; end while (!accepted && g < 2000);
    op_if.op_valid = 1'b0;
    chk("accept_timeout", (g < 2000), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] code;
    int r;
    reset_n = 1'b0; enable = 1'b1; row_clear = '0;
    op_if.op_valid = 1'b0; op_if.op_code = '0; op_if.op_x = '0; op_if.op_w = '0;
    op_if.op_y = '0; op_if.op_cfg = '0; op_if.dim_m = '0; op_if.dim_n = '0; op_if.dim_k = '0;
    repeat (3) tick();
    chk("rst_busy", op_if.busy, 0);
    chk("rst_done", op_if.done, 0);
    chk("rst_shift", shift_en, 0);
    chk("rst_we", bank_we, 0);
    chk("rst_sel", {x_sel, w_sel, y_sel}, 0);
    chk("rst_cfg", cfg_q, 0);
    chk("rst_ser_idx", ser_idx, 0);
    chk("rst_y_valid", y_valid, 0);
    mon_on = 1;
    reset_n = 1'b1;
    tick();

    // 2x2x4 matmul: x=bank0, w=bank1, y=bank2
    send(4'd1, 4'h0, 4'h4, 4'h8, 4'b0000, 1, 1, 3);
    wait_idle();
    chk("mm_shift_cnt", shift_cnt, 16);
    chk("mm_bank1_sw", m1, 64'h1_1110);
    chk("mm_bank0_sw", m0, 64'h1_0100);
    chk("mm_done_rel", done_rel, 29);

    send(4'd1, 4'h0, 4'h4, 4'h8, 4'b0001, 1, 1, 3);
    wait_idle();
    chk("tr_bank0_sw", m0, 64'h1_1110);
    chk("tr_bank1_sw", m1, 64'h1_0100);

    send(4'd1, 4'h0, 4'h4, 4'h8, 4'b1000, 1, 1, 3);
    wait_idle();
    chk("acc_we3_cnt", we3_cnt, 28);

    send(4'd2, 4'h5, 4'h0, 4'h0, 4'b0000, 0, 0, 2);
    wait_idle();
    chk("ser_we1_cnt", we1_cnt, 3);
    chk("ser_done_rel", done_rel, 4);

    send(4'd1, 4'h1, 4'h4, 4'h2, 4'b0000, 1, 1, 3);
    wait_idle();
    chk("ill_done_rel", done_rel, 1);
    chk("ill_err", done_err, 1);
    chk("ill_shift_cnt", shift_cnt, 0);

    send(4'd1, 4'h0, 4'h4, 4'h8, 4'b0000, 1, 1, 3);
    repeat (3) tick();
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    wait_idle();
    chk("frz_shift_cnt", shift_cnt, 16);
    chk("frz_done_rel", done_rel, 33);

    send(4'd1, 4'h0, 4'h4, 4'h8, 4'b0000, 1, 1, 3);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    r = done_cnt;
    chk("abort_busy", op_if.busy, 0);
    chk("abort_shift", shift_en, 0);
    chk("abort_ready", op_if.op_ready, 1);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, r);

    rand_en = 1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       code = 4'd0;
      else if (r < 10)  code = 4'd1;
      else if (r < 14)  code = 4'd2;
      else if (r < 18)  code = 4'd3;
      else              code = 4'($urandom_range(4, 15));
      send(code, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
    end
    wait_idle();
    rand_en = 0;
    enable = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
